// File: rtl/inst_rom_responder.sv
// Instruction ROM/RAM responder for the CPU fetch port.
// Returns one 32-bit word per accepted fetch after LATENCY cycles.
//
// Ports:
//   clk, rst           rising-edge clock, async active-low reset
//   inst_en_i          fetch request (held by the core until accepted)
//   inst_addr_i        fetch byte address
//   ready_o            a request can be accepted this cycle
//   inst_o             returned word, held between responses
//   inst_valid_o       one-cycle strobe per response
//   inst_err_o         response was misaligned or out of range
//   load_en_i          array write strobe
//   load_addr_i        write byte address (same mapping as fetch)
//   load_data_i        write data
module inst_rom_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = 32'h0340_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_en_i,
    input  logic [31:0] inst_addr_i,
    output logic        ready_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        inst_err_o,
    input  logic        load_en_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i
);

    localparam int AW = $clog2(DEPTH);

    // Byte span of the array, one bit wider so DEPTH*4 never wraps.
    localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

    // WAIT counts down from here; unused when LATENCY is 1.
    localparam logic [1:0] CNT_INIT =
        (LATENCY >= 2) ? 2'(LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Storage. Not reset: contents survive a core reset.
    logic [31:0] r_mem [DEPTH];

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic        r_ready;
    logic        r_valid;
    logic [31:0] r_data;
    logic        r_err;
    logic [31:0] r_pend_data;
    logic        r_pend_err;

    // Fetch decode
    logic [31:0]   w_foff;
    logic          w_ferr;
    logic [AW-1:0] w_fidx;
    logic [31:0]   w_fword;
    logic [31:0]   w_fdata;

    // Load decode
    logic [31:0]   w_loff;
    logic          w_lerr;
    logic [AW-1:0] w_lidx;

    logic          w_accept;

    assign w_foff  = inst_addr_i - BASE_ADDR;
    assign w_ferr  = (w_foff[1:0] != 2'b00) ||
                     ({1'b0, w_foff} >= LIMIT);
    assign w_fidx  = w_foff[AW+1:2];
    assign w_fword = r_mem[w_fidx];
    assign w_fdata = w_ferr ? NOP_WORD : w_fword;

    assign w_loff  = load_addr_i - BASE_ADDR;
    assign w_lerr  = (w_loff[1:0] != 2'b00) ||
                     ({1'b0, w_loff} >= LIMIT);
    assign w_lidx  = w_loff[AW+1:2];

    assign w_accept = inst_en_i && r_ready;

    // The fetch reads w_fword combinationally in the same cycle this
    // write is scheduled, so a same-edge load/fetch sees the old word.
    always_ff @(posedge clk) begin
        if (load_en_i && !w_lerr) begin
            r_mem[w_lidx] <= load_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= 2'd0;
            r_ready     <= 1'b1;
            r_valid     <= 1'b0;
            r_data      <= 32'd0;
            r_err       <= 1'b0;
            r_pend_data <= 32'd0;
            r_pend_err  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                IDLE, RESP: begin
                    if (w_accept) begin
                        if (LATENCY == 1) begin
                            // Straight to RESP: one word per cycle.
                            r_state <= RESP;
                            r_valid <= 1'b1;
                            r_data  <= w_fdata;
                            r_err   <= w_ferr;
                            r_ready <= 1'b1;
                        end else begin
                            // Park the word so inst_o holds the
                            // previous response while waiting.
                            r_state     <= WAIT;
                            r_cnt       <= CNT_INIT;
                            r_pend_data <= w_fdata;
                            r_pend_err  <= w_ferr;
                            r_ready     <= 1'b0;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_state <= RESP;
                        r_valid <= 1'b1;
                        r_data  <= r_pend_data;
                        r_err   <= r_pend_err;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o      = r_ready;
    assign inst_o       = r_data;
    assign inst_valid_o = r_valid;
    assign inst_err_o   = r_err;

endmodule

// File: tb/tb_inst_rom_responder.sv
// Bench for inst_rom_responder: three instances (LATENCY 1, 3, 4)
// checked each cycle against a queue-based response model.
module tb_inst_rom_responder;

    localparam logic [31:0] NOP = 32'h0340_0000;
    localparam int LAT [3] = '{1, 3, 4};

    typedef struct packed {
        int          due;
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        rst4;
    logic        en_i   [3];
    logic [31:0] addr_i [3];
    logic        rdy    [3];
    logic [31:0] data_o [3];
    logic        vld    [3];
    logic        err_o  [3];
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    int nvec;
    int nerr;

    // Model state
    logic [31:0] mem_m [1024];
    exp_t        q [3][$];
    int          free_e [3];
    logic [31:0] ld [3];
    logic        le [3];
    int          ecnt;
    logic [31:0] off;
    exp_t        x;
    logic        rd;
    logic        rdc;
    logic        expv;
    logic        exprdy;
    int          vcount;

    inst_rom_responder #(.LATENCY(1)) u1 (
        .clk(clk), .rst(rst),
        .inst_en_i(en_i[0]), .inst_addr_i(addr_i[0]),
        .ready_o(rdy[0]), .inst_o(data_o[0]),
        .inst_valid_o(vld[0]), .inst_err_o(err_o[0]),
        .load_en_i(ld_en), .load_addr_i(ld_addr),
        .load_data_i(ld_data)
    );

    inst_rom_responder #(.LATENCY(3)) u3 (
        .clk(clk), .rst(rst),
        .inst_en_i(en_i[1]), .inst_addr_i(addr_i[1]),
        .ready_o(rdy[1]), .inst_o(data_o[1]),
        .inst_valid_o(vld[1]), .inst_err_o(err_o[1]),
        .load_en_i(ld_en), .load_addr_i(ld_addr),
        .load_data_i(ld_data)
    );

    inst_rom_responder #(.LATENCY(4)) u4 (
        .clk(clk), .rst(rst4),
        .inst_en_i(en_i[2]), .inst_addr_i(addr_i[2]),
        .ready_o(rdy[2]), .inst_o(data_o[2]),
        .inst_valid_o(vld[2]), .inst_err_o(err_o[2]),
        .load_en_i(ld_en), .load_addr_i(ld_addr),
        .load_data_i(ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int d,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d] t=%0t got %h want %h",
                     nm, d, $time, act, exp);
        end
    endtask

    // Model: accepted fetch at edge e is shown in the cycle after
    // edge e+LAT-1; the next accept is allowed from edge e+LAT.
    always @(posedge clk) begin
        ecnt++;
        for (int d = 0; d < 3; d++) begin
            rd = (d == 2) ? rst4 : rst;
            if (!rd) begin
                q[d].delete();
                free_e[d] = 0;
                ld[d] = 32'd0;
                le[d] = 1'b0;
            end else begin
                while (q[d].size() > 0 && q[d][0].due < ecnt)
                    void'(q[d].pop_front());
                if (en_i[d] && ecnt >= free_e[d]) begin
                    off = addr_i[d];
                    x.e = (off[1:0] != 2'b00) || (off >= 32'd4096);
                    x.d = x.e ? NOP : mem_m[off[11:2]];
                    x.due = ecnt + LAT[d] - 1;
                    q[d].push_back(x);
                    free_e[d] = ecnt + LAT[d];
                end
                if (q[d].size() > 0 && q[d][0].due == ecnt) begin
                    ld[d] = q[d][0].d;
                    le[d] = q[d][0].e;
                end
            end
        end
        if (ld_en) begin
            off = ld_addr;
            if (off[1:0] == 2'b00 && off < 32'd4096)
                mem_m[off[11:2]] = ld_data;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            rdc = (d == 2) ? rst4 : rst;
            if (!rdc) begin
                check("rst_ready", d, 32'(rdy[d]), 32'd1);
                check("rst_valid", d, 32'(vld[d]), 32'd0);
                check("rst_data", d, data_o[d], 32'd0);
                check("rst_err", d, 32'(err_o[d]), 32'd0);
            end else begin
                expv = (q[d].size() > 0) && (q[d][0].due == ecnt);
                exprdy = (ecnt + 1 >= free_e[d]);
                check("valid", d, 32'(vld[d]), 32'(expv));
                check("ready", d, 32'(rdy[d]), 32'(exprdy));
                check("data", d, data_o[d], ld[d]);
                check("err", d, 32'(err_o[d]), 32'(le[d]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] v);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = v;
        tick();
        ld_en = 1'b0;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        ecnt = 0;
        vcount = 0;
        for (int i = 0; i < 1024; i++) mem_m[i] = 32'd0;
        for (int d = 0; d < 3; d++) begin
            en_i[d] = 1'b0;
            addr_i[d] = 32'd0;
            free_e[d] = 0;
            ld[d] = 32'd0;
            le[d] = 1'b0;
        end
        ld_en = 1'b0;
        ld_addr = 32'd0;
        ld_data = 32'd0;
        rst = 1'b1;
        rst4 = 1'b1;
        #1;
        rst = 1'b0;
        rst4 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        rst4 = 1'b1;

        load(32'h00, 32'h0280_0421);
        load(32'h04, 32'h1111_1111);
        load(32'h08, 32'h2222_2222);
        load(32'h10, 32'h1234_5678);
        load(32'h20, 32'h3333_3333);
        load(32'h24, 32'h4444_4444);
        tick();

        // LATENCY 1: single fetch, then back-to-back 0,4,8
        en_i[0] = 1'b1;
        addr_i[0] = 32'h0;
        tick();
        check("t1_valid", 0, 32'(vld[0]), 32'd1);
        check("t1_data", 0, data_o[0], 32'h0280_0421);
        check("t1_err", 0, 32'(err_o[0]), 32'd0);
        addr_i[0] = 32'h4;
        tick();
        check("t2_data4", 0, data_o[0], 32'h1111_1111);
        check("t2_ready", 0, 32'(rdy[0]), 32'd1);
        addr_i[0] = 32'h8;
        tick();
        check("t2_data8", 0, data_o[0], 32'h2222_2222);
        check("t2_valid", 0, 32'(vld[0]), 32'd1);
        en_i[0] = 1'b0;
        tick();
        check("t2_idle", 0, 32'(vld[0]), 32'd0);
        check("t2_hold", 0, data_o[0], 32'h2222_2222);

        // LATENCY 3: fetch 0x20, then 0x24 raised during WAIT
        en_i[1] = 1'b1;
        addr_i[1] = 32'h20;
        tick();
        check("t3_busy1", 1, 32'(rdy[1]), 32'd0);
        addr_i[1] = 32'h24;
        tick();
        check("t3_busy2", 1, 32'(rdy[1]), 32'd0);
        check("t3_novld", 1, 32'(vld[1]), 32'd0);
        tick();
        check("t3_vld20", 1, 32'(vld[1]), 32'd1);
        check("t3_dat20", 1, data_o[1], 32'h3333_3333);
        check("t3_rdy", 1, 32'(rdy[1]), 32'd1);
        tick();
        en_i[1] = 1'b0;
        check("t3_busy3", 1, 32'(rdy[1]), 32'd0);
        tick();
        tick();
        check("t3_vld24", 1, 32'(vld[1]), 32'd1);
        check("t3_dat24", 1, data_o[1], 32'h4444_4444);
        tick();

        // Error fetches and a dropped out-of-range load
        en_i[0] = 1'b1;
        addr_i[0] = 32'h2;
        tick();
        check("t4_mis_d", 0, data_o[0], NOP);
        check("t4_mis_e", 0, 32'(err_o[0]), 32'd1);
        addr_i[0] = 32'h1000;
        tick();
        check("t4_oor_d", 0, data_o[0], NOP);
        check("t4_oor_e", 0, 32'(err_o[0]), 32'd1);
        en_i[0] = 1'b0;
        load(32'h1000, 32'hDEAD_BEEF);
        en_i[0] = 1'b1;
        addr_i[0] = 32'h0;
        tick();
        en_i[0] = 1'b0;
        check("t4_keep", 0, data_o[0], 32'h0280_0421);
        check("t4_noerr", 0, 32'(err_o[0]), 32'd0);

        // Same-edge load and fetch
        en_i[0] = 1'b1;
        addr_i[0] = 32'h10;
        ld_en = 1'b1;
        ld_addr = 32'h10;
        ld_data = 32'hAAAA_5555;
        tick();
        ld_en = 1'b0;
        check("t5_old", 0, data_o[0], 32'h1234_5678);
        tick();
        en_i[0] = 1'b0;
        check("t5_new", 0, data_o[0], 32'hAAAA_5555);
        tick();

        // LATENCY 4: full fetch, then reset during WAIT
        en_i[2] = 1'b1;
        addr_i[2] = 32'h4;
        tick();
        en_i[2] = 1'b0;
        tick();
        tick();
        tick();
        check("t6_vld", 2, 32'(vld[2]), 32'd1);
        check("t6_dat", 2, data_o[2], 32'h1111_1111);
        tick();
        en_i[2] = 1'b1;
        addr_i[2] = 32'h0;
        tick();
        en_i[2] = 1'b0;
        tick();
        check("t6_wait", 2, 32'(rdy[2]), 32'd0);
        rst4 = 1'b0;
        #1;
        check("t6_rrdy", 2, 32'(rdy[2]), 32'd1);
        check("t6_rdat", 2, data_o[2], 32'd0);
        check("t6_rvld", 2, 32'(vld[2]), 32'd0);
        tick();
        tick();
        rst4 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (vld[2]) vcount++;
        end
        check("t6_stray", 2, 32'(vcount), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
